// File: rtl/seq_check_pkg.sv
// Shared definitions for the incrementing-count sequence checker:
// user I/O pin map, output-enable polarity and checker state encoding.
package seq_check_pkg;

  localparam int unsigned IO_WIDTH    = 24;
  localparam int unsigned PIN_LOCKED  = 23;
  localparam int unsigned PIN_EN      = 22;
  localparam int unsigned PIN_DISP_HI = 21;
  localparam int unsigned PIN_DISP_LO = 12;
  localparam int unsigned PIN_SEL     = 11;
  localparam int unsigned PIN_CLR     = 10;
  localparam int unsigned PIN_BUS_HI  = 9;
  localparam int unsigned PIN_BUS_LO  = 0;

  localparam logic OUTPUT_ENABLE  = 1'b1;
  localparam logic OUTPUT_DISABLE = 1'b0;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } chk_state_e;

endpackage

// File: rtl/seq_checker_16bit_if.sv
// User I/O pin bundle of the fabric user design (inputs, outputs, enables).
interface seq_checker_16bit_if;
  import seq_check_pkg::*;

  logic [IO_WIDTH-1:0] io_in;
  logic [IO_WIDTH-1:0] io_out;
  logic [IO_WIDTH-1:0] io_oeb;

  modport master (output io_in, input io_out, input io_oeb);
  modport slave  (input io_in, output io_out, output io_oeb);
endinterface

// File: rtl/seq_check_sync_filter.sv
// Two-flop synchroniser for the count bus and control pins, followed by a
// stability filter that emits a one-cycle accept for each new stable value.
module seq_check_sync_filter #(
  parameter int unsigned DATA_WIDTH    = 10,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] bus_pin,
  input  logic                  clr_pin,
  input  logic                  sel_pin,
  input  logic                  en_pin,
  output logic                  accept,
  output logic [DATA_WIDTH-1:0] acc_value,
  output logic                  clr_s,
  output logic                  sel_s,
  output logic                  en_s
);

  localparam int unsigned CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [DATA_WIDTH-1:0] bus_s1, bus_s2;
  logic [2:0]            ctl_s1, ctl_s2;
  logic [DATA_WIDTH-1:0] cand_q, last_acc_q;
  logic [CNT_W-1:0]      cnt_q;

  // Two-stage synchronisers for bus and {en, sel, clr}.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_s1 <= '0;
      bus_s2 <= '0;
      ctl_s1 <= '0;
      ctl_s2 <= '0;
    end else begin
      bus_s1 <= bus_pin;
      bus_s2 <= bus_s1;
      ctl_s1 <= {en_pin, sel_pin, clr_pin};
      ctl_s2 <= ctl_s1;
    end
  end

  // Candidate/stability counter; remember the last accepted value so a
  // value that reappears after a glitch is not accepted twice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q     <= '0;
      cnt_q      <= '0;
      last_acc_q <= '0;
    end else begin
      if (bus_s2 != cand_q) begin
        cand_q <= bus_s2;
        cnt_q  <= '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (accept) begin
        last_acc_q <= cand_q;
      end
    end
  end

  assign accept    = (cnt_q == CNT_MAX) && (cand_q != last_acc_q);
  assign acc_value = cand_q;
  assign en_s      = ctl_s2[2];
  assign sel_s     = ctl_s2[1];
  assign clr_s     = ctl_s2[0];

endmodule

// File: rtl/seq_checker_16bit.sv
// Sequence checker user design: locks onto a +1 count pattern on io_in[9:0],
// counts sequence breaks while locked and shows them on io_out[21:12].
// Optional feature macro: SEQ_CHECK_LAST_BAD_EN (last bad value register and
// display select on io_in[11]).
module seq_checker_16bit
  import seq_check_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 10,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned LOCK_COUNT    = 8,
  parameter int unsigned ERR_WIDTH     = 10
) (
  input logic                clk,
  input logic                rst_n,
  seq_checker_16bit_if.slave pins
);

  localparam int unsigned RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int unsigned DISP_W = PIN_DISP_HI - PIN_DISP_LO + 1;

  logic                  accept;
  logic [DATA_WIDTH-1:0] acc_value;
  logic                  clr_s, sel_s, en_s;
  logic                  clr_d_q;
  logic                  clr_rise;
  logic                  correct;
  logic                  err_hit;
  chk_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] ref_q, ref_d;
  logic [RUN_W-1:0]      run_q, run_d;
  logic [ERR_WIDTH-1:0]  err_q, err_d;
  logic [ERR_WIDTH-1:0]  disp;
  logic [IO_WIDTH-1:0]   out_w, oeb_w;
  logic                  unused_pins;

  seq_check_sync_filter #(
    .DATA_WIDTH    (DATA_WIDTH),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_sync_filter (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_pin   (pins.io_in[PIN_BUS_LO +: DATA_WIDTH]),
    .clr_pin   (pins.io_in[PIN_CLR]),
    .sel_pin   (pins.io_in[PIN_SEL]),
    .en_pin    (pins.io_in[PIN_EN]),
    .accept    (accept),
    .acc_value (acc_value),
    .clr_s     (clr_s),
    .sel_s     (sel_s),
    .en_s      (en_s)
  );

  assign correct  = (acc_value == DATA_WIDTH'(ref_q + 1'b1));
  assign clr_rise = clr_s && !clr_d_q;

  // Next-state logic: enable low overrides everything and drops lock.
  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    run_d   = run_q;
    err_hit = 1'b0;
    if (!en_s) begin
      state_d = UNLOCKED;
    end else if (accept) begin
      ref_d = acc_value;
      case (state_q)
        UNLOCKED: begin
          run_d   = '0;
          state_d = ACQUIRE;
        end
        ACQUIRE: begin
          if (correct) begin
            run_d = run_q + 1'b1;
            if (run_d == RUN_W'(LOCK_COUNT)) begin
              state_d = LOCKED;
            end
          end else begin
            run_d = '0;
          end
        end
        LOCKED: begin
          if (!correct) begin
            err_hit = 1'b1;
            run_d   = '0;
            state_d = ACQUIRE;
          end
        end
        default: state_d = UNLOCKED;
      endcase
    end
  end

  // Error counter next value: clear edge beats a simultaneous error.
  always_comb begin
    err_d = err_q;
    if (clr_rise) begin
      err_d = '0;
    end else if (err_hit && (err_q != '1)) begin
      err_d = err_q + 1'b1;
    end
  end

  // Checker state, reference, run length, error count, clear edge detector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UNLOCKED;
      ref_q   <= '0;
      run_q   <= '0;
      err_q   <= '0;
      clr_d_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      run_q   <= run_d;
      err_q   <= err_d;
      clr_d_q <= clr_s;
    end
  end

`ifdef SEQ_CHECK_LAST_BAD_EN
  logic [DATA_WIDTH-1:0] last_bad_q;

  // Capture the offending value of each counted sequence break.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_bad_q <= '0;
    end else if (err_hit) begin
      last_bad_q <= acc_value;
    end
  end

  assign disp        = sel_s ? ERR_WIDTH'(last_bad_q) : err_q;
  assign unused_pins = ^{pins.io_in[PIN_LOCKED], pins.io_in[PIN_DISP_HI:PIN_DISP_LO]};
`else
  assign disp        = err_q;
  assign unused_pins = ^{pins.io_in[PIN_LOCKED], pins.io_in[PIN_DISP_HI:PIN_DISP_LO], sel_s};
`endif

  // Output pin assembly and fixed output enables.
  always_comb begin
    out_w                           = '0;
    out_w[PIN_LOCKED]               = (state_q == LOCKED);
    out_w[PIN_DISP_LO +: ERR_WIDTH] = disp;
    oeb_w                           = {IO_WIDTH{OUTPUT_DISABLE}};
    oeb_w[PIN_LOCKED]               = OUTPUT_ENABLE;
    oeb_w[PIN_DISP_LO +: DISP_W]    = {DISP_W{OUTPUT_ENABLE}};
  end

  assign pins.io_out = out_w;
  assign pins.io_oeb = oeb_w;

endmodule

// File: tb/tb_seq_checker_16bit.sv
// Self-checking bench for seq_checker_16bit: table of count vectors, hand
// sequences for glitch/clear/enable/reset corners, and a randomized run
// checked against a rule-level reference model.
module tb_seq_checker_16bit;
  import seq_check_pkg::*;

  localparam int unsigned DW   = 10;
  localparam int unsigned SC   = 4;
  localparam int unsigned LC   = 8;
  localparam int unsigned HOLD = 10;
  localparam int unsigned MODV = 1 << DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_checker_16bit_if pins();

  seq_checker_16bit #(
    .DATA_WIDTH    (DW),
    .STABLE_CYCLES (SC),
    .LOCK_COUNT    (LC),
    .ERR_WIDTH     (DW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pins  (pins)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned value;
    bit          exp_locked;
    int unsigned exp_err;
  } vec_t;

  vec_t vecs[$];

  // reference model state
  int unsigned m_last_acc, m_ref, m_run, m_err, m_last_bad;
  int          m_phase;  // 0 waiting for first value, 1 acquiring, 2 locked

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input bit exp_locked, input int unsigned exp_disp);
    check({name, " locked"}, 32'(pins.io_out[PIN_LOCKED]), 32'(exp_locked));
    check({name, " display"}, 32'(pins.io_out[PIN_DISP_HI:PIN_DISP_LO]), exp_disp);
    check({name, " idle bits"}, 32'({pins.io_out[PIN_EN], pins.io_out[PIN_SEL:0]}), 32'd0);
  endtask

  task automatic wait_edges(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_bus(input int unsigned v);
    pins.io_in[PIN_BUS_HI:PIN_BUS_LO] = DW'(v);
  endtask

  task automatic drive(input int unsigned v);
    set_bus(v);
    wait_edges(HOLD);
  endtask

  task automatic model_reset();
    m_last_acc = 0;
    m_ref      = 0;
    m_run      = 0;
    m_err      = 0;
    m_last_bad = 0;
    m_phase    = 0;
  endtask

  // Apply one bus value held for 'hold' cycles with enable level 'en'.
  task automatic model_present(input int unsigned v, input int unsigned hold, input bit en);
    bit acc;
    bit ok;
    acc = (hold >= SC) && (v != m_last_acc);
    if (acc) m_last_acc = v;
    if (!en) begin
      m_phase = 0;
    end else if (acc) begin
      ok = (v == (m_ref + 1) % MODV);
      if (m_phase == 0) begin
        m_run   = 0;
        m_phase = 1;
      end else if (m_phase == 1) begin
        if (ok) begin
          m_run++;
          if (m_run == LC) m_phase = 2;
        end else begin
          m_run = 0;
        end
      end else if (!ok) begin
        if (m_err < MODV - 1) m_err++;
        m_last_bad = v;
        m_run      = 0;
        m_phase    = 1;
      end
      m_ref = v;
    end
  endtask

  initial begin
    int unsigned cur, v, hold, g, r;
    bit en;

    // vector table: value held HOLD cycles, expected lock and error count
    for (int unsigned i = 0; i <= 20; i++) vecs.push_back('{i, i >= 9, 0});
    vecs.push_back('{1020, 0, 1});
    for (int unsigned i = 1021; i <= 1023; i++) vecs.push_back('{i, 0, 1});
    for (int unsigned i = 0; i <= 3; i++) vecs.push_back('{i, 0, 1});
    vecs.push_back('{4, 1, 1});
    vecs.push_back('{5, 1, 1});
    vecs.push_back('{1012, 0, 2});
    for (int unsigned i = 1013; i <= 1019; i++) vecs.push_back('{i, 0, 2});
    for (int unsigned i = 1020; i <= 1023; i++) vecs.push_back('{i, 1, 2});
    vecs.push_back('{0, 1, 2});
    vecs.push_back('{1, 1, 2});

    pins.io_in = '0;
    pins.io_in[PIN_EN] = 1'b1;
    #12;
    check_out("reset", 0, 0);
    check("oeb", 32'(pins.io_oeb), 32'h00BF_F000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].value);
      check_out($sformatf("vec%0d v=%0d", i, vecs[i].value), vecs[i].exp_locked, vecs[i].exp_err);
    end

    // glitches of 1..STABLE_CYCLES-1 cycles to 0x3FF are discarded
    for (int unsigned k = 1; k <= SC - 1; k++) begin
      set_bus(10'h3FF);
      wait_edges(k);
      drive(1 + k);
      check_out($sformatf("glitch len %0d", k), 1, 2);
    end

    // skip while locked
    drive(5);
    check_out("pre-skip", 1, 2);
`ifdef SEQ_CHECK_LAST_BAD_EN
    pins.io_in[PIN_SEL] = 1'b1;
    drive(7);
    check_out("skip last_bad", 0, 7);
    pins.io_in[PIN_SEL] = 1'b0;
`else
    drive(7);
    check_out("skip", 0, 3);
`endif
    for (int unsigned i = 8; i <= 15; i++) begin
      drive(i);
      check_out($sformatf("relock v=%0d", i), i >= 15, 3);
    end

    // clear edge lands on the same edge as the error
    set_bus(40);
    wait_edges(SC);
    pins.io_in[PIN_CLR] = 1'b1;
    wait_edges(HOLD - SC);
    check_out("clear collision", 0, 0);
    for (int unsigned i = 41; i <= 48; i++) drive(i);
    check_out("lock after clear", 1, 0);
    drive(60);
    check_out("clear level no effect", 0, 1);
    pins.io_in[PIN_CLR] = 1'b0;
`ifdef SEQ_CHECK_LAST_BAD_EN
    pins.io_in[PIN_SEL] = 1'b1;
    wait_edges(3);
    check_out("last_bad kept by clear", 0, 60);
    pins.io_in[PIN_SEL] = 1'b0;
    wait_edges(3);
`endif
    for (int unsigned i = 61; i <= 68; i++) drive(i);
    check_out("lock before enable low", 1, 1);

    // enable low: lock drops on the third edge, err holds, accepts ignored
    pins.io_in[PIN_EN] = 1'b0;
    wait_edges(2);
    check_out("enable latency", 1, 1);
    wait_edges(1);
    check_out("enable low", 0, 1);
    drive(100);
    check_out("enable low accept ignored", 0, 1);
    pins.io_in[PIN_EN] = 1'b1;
    wait_edges(3);
    drive(101);
    check_out("enable restored", 0, 1);
    for (int unsigned i = 102; i <= 109; i++) drive(i);
    check_out("lock before reset", 1, 1);

    // asynchronous reset mid-run
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_out("async reset", 0, 0);
    set_bus(0);
    wait_edges(3);
    rst_n = 1'b1;
    wait_edges(3);
    drive(500);
    check_out("first after reset", 0, 0);
    for (int unsigned i = 501; i <= 508; i++) begin
      drive(i);
      check_out($sformatf("post-reset v=%0d", i), i >= 508, 0);
    end

    // randomized run against the reference model
    rst_n = 1'b0;
    set_bus(0);
    pins.io_in[PIN_EN] = 1'b1;
    wait_edges(2);
    rst_n = 1'b1;
    wait_edges(2);
    model_reset();
    cur = 0;
    for (int i = 0; i < 250; i++) begin
      r  = $urandom_range(99);
      en = ($urandom_range(29) != 0);
      pins.io_in[PIN_EN] = en;
      if (r < 70) begin
        v = (cur + 1) % MODV;
      end else if (r < 80) begin
        v = $urandom_range(MODV - 1);
      end else if (r < 88) begin
        v = cur;
      end else begin
        g = $urandom_range(SC - 1, 1);
        set_bus($urandom_range(MODV - 1));
        wait_edges(g);
        model_present(32'(pins.io_in[PIN_BUS_HI:PIN_BUS_LO]), g, en);
        v = (cur + 1) % MODV;
      end
      hold = $urandom_range(SC + 7, SC + 3);
      set_bus(v);
      wait_edges(hold);
      model_present(v, hold, en);
      check_out($sformatf("rand%0d v=%0d", i, v), m_phase == 2, m_err);
      cur = v;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_checker_16bit.md
# seq_checker_16bit

User-design top for the FABulous fabric that checks an incrementing count pattern arriving on the user I/O pins, such as the one produced by the fabric's LED counter design on a second board. It synchronises and deglitches the incoming bus, locks onto a clean +1 sequence, and counts sequence breaks. It shows the result on the upper LED pins, together with a lock indicator.

## Interface
Parameters:
- DATA_WIDTH, 10, width of the incoming count bus.
- STABLE_CYCLES, 4, consecutive identical synchronised samples required before a bus value is accepted (min 1).
- LOCK_COUNT, 8, consecutive correct increments required to declare lock (min 1).
- ERR_WIDTH, 10, error counter width; must equal DATA_WIDTH (display width).

Ports:
- clk  input  1  fabric user clock.
- rst_n  input  1  asynchronous, active-low reset.
- io_in  input  24  [9:0] count bus; [10] clear button; [11] display-select switch; [22] check enable; others unused.
- io_out  output  24  [21:12] display; [23] locked; all other bits driven 0.
- io_oeb  output  24  Output enable, 1 = driven (team OUTPUT_ENABLE = 1'b1):
  - [23] and [21:12] tied to 1.
  - All other bits tied to 0.

## Operation
- **Input synchronisation.** io_in[9:0], [10], [11] and [22] each pass through two flops.
- **Stability filter.**
  - Holds a candidate register and a stability counter.
  - When the synchronised bus differs from the candidate: load the candidate and clear the counter.
  - When it equals the candidate: the counter increments, saturating at STABLE_CYCLES-1.
  - An accept pulse fires for one cycle when the counter reaches STABLE_CYCLES-1 and the candidate differs from the last accepted value.
  - Repeated or unchanged values never produce a second accept.
- **Check rule.** An accepted value v is correct iff v == (ref + 1) mod 2^DATA_WIDTH. The wrap 1023 -> 0 is correct.
- **State machine (UNLOCKED, ACQUIRE, LOCKED).**
  - UNLOCKED, on accept: ref <= v, run <= 0, go to ACQUIRE.
  - ACQUIRE, correct: ref <= v, run++. When run reaches LOCK_COUNT, go to LOCKED.
  - ACQUIRE, incorrect: ref <= v, run <= 0. No error is counted.
  - LOCKED, correct: ref <= v, stay.
  - LOCKED, incorrect: err++ (saturating at 2^ERR_WIDTH-1), last_bad <= v, ref <= v, run <= 0, go to ACQUIRE.
- **Enable low** (synchronised io_in[22] = 0):
  - State forced to UNLOCKED; accepts are ignored.
  - err and last_bad hold.
- **Clear.** A rising edge of the synchronised io_in[10] clears err to 0.
  - If an error occurs in the same cycle, the clear wins: err = 0.
  - last_bad is not cleared.
- **Outputs.**
  - io_out[23] = (state == LOCKED).
  - io_out[21:12] = err, or last_bad (see Configuration).
- **Reset values.** All flops 0; state UNLOCKED; io_out all 0.

## Timing
- E = the first clk edge at which the pins show a new stable value.
- The accept pulse is high in the cycle after edge E+1+STABLE_CYCLES.
- state, err, last_bad and io_out update at the next edge, E+2+STABLE_CYCLES. Total latency is STABLE_CYCLES+2 edges.
- Clear and enable take effect 3 edges after the pin changes: 2 synchroniser edges plus 1 register edge.
- Bus values held for fewer than STABLE_CYCLES synchronised cycles are discarded silently.
- Reset deasserted mid-sequence: the checker restarts from UNLOCKED. The first accept only loads ref and never counts an error.

## Configuration
- SEQ_CHECK_LAST_BAD_EN
  - Defined: the last_bad register exists. Synchronised io_in[11] = 1 selects last_bad on the display; 0 selects err.
  - Undefined: no last_bad register; the display always shows err and io_in[11] is ignored.
  - All other behaviour is identical in both builds.

## Structure
- **Package seq_check_pkg:**
  - Pin index localparams (23, 22, 21:12, 11, 10, 9:0).
  - OUTPUT_ENABLE / OUTPUT_DISABLE.
  - State enum {UNLOCKED, ACQUIRE, LOCKED}.
- **Sub-module seq_check_sync_filter:**
  - Contains the two-flop synchroniser and the stability filter.
  - Outputs: accept pulse, accepted value, synchronised control bits.
- The top contains the FSM, counters, output muxing and oeb tie-offs.

## Test plan
- **Clean count.** Drive 0..20, each value held 10 cycles, enable = 1 -> io_out[23] rises on accept of value 9 (LOCK_COUNT = 8); err stays 0.
- **Wrap.** After lock, drive 1020..1023, 0, 1 -> lock held; err = 0.
- **Skip while locked.** Drive 5 after 3 -> err = 1, io_out[23] falls. With the switch set (macro defined), the display shows 5. Lock returns after 8 more correct values.
- **Glitch rejection.** Drive a 2-cycle excursion to 0x3FF between 6 and 7 -> no accept of 0x3FF; err unchanged.
- **Clear/error collision.** Rising edge on io_in[10] in the same cycle as an error -> err = 0.
- **Enable low and reset.**
  - Enable low: state UNLOCKED and err holds.
  - rst_n low mid-run: all outputs 0 asynchronously.
  - After reset release, first value 500 -> no error counted.
